// File: rtl/membus_arbiter.sv
// -----------------------------------------------------------------------------
// membus_arbiter
//
// Shares the external memory bus between the instruction-fetch port (f_*) and
// the operand load/store port (d_*). Each transfer runs as one address-phase
// cycle followed by a data phase that ends on i_rdy (after WAIT_STATES cycles)
// or is aborted after TIMEOUT data cycles.
//
// Ports
//   clk, reset            clock; synchronous active-high reset
//   f_req/f_addr          fetch request and address (held until f_gnt)
//   f_gnt/f_done          fetch latched / fetch data valid pulses
//   d_req/d_opc/d_we/...  data request, opcode, direction, address, write data,
//                         write tag, write-protect override (held until d_gnt)
//   d_gnt/d_done/d_err    data latched / data complete / timeout qualifier
//   rd_data/rd_tag        read data and tag captured at the end of a read
//   o_ad/o_tag/o_astb/o_rd/o_wr/o_wforce/o_opc   bus pad outputs
//   i_data/i_tag/i_rdy    bus read data, read tag, slave ready
//   busy                  a transfer is in progress
//
// Every output is a flop; the always_comb block computes the value each one
// takes on the next edge.
// -----------------------------------------------------------------------------
module membus_arbiter #(
   parameter int unsigned WAIT_STATES  = 0,
   parameter int unsigned MAX_DATA_RUN = 2,
   parameter int unsigned TIMEOUT      = 64
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        f_req,
   input  logic [19:0] f_addr,
   output logic        f_gnt,
   output logic        f_done,
   input  logic        d_req,
   input  logic [3:0]  d_opc,
   input  logic        d_we,
   input  logic [19:0] d_addr,
   input  logic [63:0] d_wdata,
   input  logic [7:0]  d_wtag,
   input  logic        d_wforce,
   output logic        d_gnt,
   output logic        d_done,
   output logic        d_err,
   output logic [63:0] rd_data,
   output logic [7:0]  rd_tag,
   output logic [63:0] o_ad,
   output logic [7:0]  o_tag,
   output logic        o_astb,
   output logic        o_rd,
   output logic        o_wr,
   output logic        o_wforce,
   output logic [3:0]  o_opc,
   input  logic [63:0] i_data,
   input  logic [7:0]  i_tag,
   input  logic        i_rdy,
   output logic        busy
);

   localparam logic [3:0]    OPC_FETCH = 4'd8;
   localparam int unsigned   CW        = $clog2(TIMEOUT + WAIT_STATES + 1);
   localparam logic [CW-1:0] WS_LAST   = CW'(WAIT_STATES);
   localparam logic [CW-1:0] TO_LAST   = CW'(TIMEOUT - 1);
   localparam int unsigned   RW        = $clog2(MAX_DATA_RUN + 2);
   localparam logic [RW-1:0] RUN_MAX   = RW'(MAX_DATA_RUN);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ADDR = 2'd1,
      ST_DATA = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] wcnt_q, wcnt_d;
   logic          ws_ok_q, ws_ok_d;      // wait states have elapsed, i_rdy may end the phase
   logic [RW-1:0] run_cnt_q, run_cnt_d;

   // Fields of the transfer currently owning the bus
   logic          xfer_fetch_q, xfer_fetch_d;
   logic          xfer_we_q, xfer_we_d;
   logic [19:0]   xfer_addr_q, xfer_addr_d;
   logic [63:0]   xfer_wdata_q, xfer_wdata_d;
   logic [7:0]    xfer_wtag_q, xfer_wtag_d;
   logic          xfer_wforce_q, xfer_wforce_d;
   logic [3:0]    xfer_opc_q, xfer_opc_d;

   // Registered outputs
   logic          f_gnt_q, f_gnt_d, f_done_q, f_done_d;
   logic          d_gnt_q, d_gnt_d, d_done_q, d_done_d, d_err_q, d_err_d;
   logic [63:0]   rd_data_q, rd_data_d;
   logic [7:0]    rd_tag_q, rd_tag_d;
   logic [63:0]   o_ad_q, o_ad_d;
   logic [7:0]    o_tag_q, o_tag_d;
   logic          o_astb_q, o_astb_d, o_rd_q, o_rd_d, o_wr_q, o_wr_d;
   logic          o_wforce_q, o_wforce_d;
   logic [3:0]    o_opc_q, o_opc_d;
   logic          busy_q, busy_d;

   logic          fetch_win;
   logic          drive_data;

   always_comb begin
      state_d       = state_q;
      wcnt_d        = wcnt_q;
      ws_ok_d       = ws_ok_q;
      // The data-run count only means something while a fetch is waiting.
      run_cnt_d     = f_req ? run_cnt_q : '0;
      xfer_fetch_d  = xfer_fetch_q;
      xfer_we_d     = xfer_we_q;
      xfer_addr_d   = xfer_addr_q;
      xfer_wdata_d  = xfer_wdata_q;
      xfer_wtag_d   = xfer_wtag_q;
      xfer_wforce_d = xfer_wforce_q;
      xfer_opc_d    = xfer_opc_q;
      f_gnt_d       = 1'b0;
      f_done_d      = 1'b0;
      d_gnt_d       = 1'b0;
      d_done_d      = 1'b0;
      d_err_d       = 1'b0;
      rd_data_d     = rd_data_q;
      rd_tag_d      = rd_tag_q;
      o_ad_d        = '0;
      o_tag_d       = '0;
      o_astb_d      = 1'b0;
      o_rd_d        = 1'b0;
      o_wr_d        = 1'b0;
      o_wforce_d    = 1'b0;
      o_opc_d       = '0;
      drive_data    = 1'b0;

      // Data normally wins; a fetch that has watched MAX_DATA_RUN data
      // grants go by takes the bus next.
      fetch_win = f_req && (!d_req || (run_cnt_q == RUN_MAX));

      case (state_q)
         ST_IDLE: begin
            if (f_req || d_req) begin
               state_d  = ST_ADDR;
               o_astb_d = 1'b1;
               if (fetch_win) begin
                  xfer_fetch_d  = 1'b1;
                  xfer_we_d     = 1'b0;
                  xfer_addr_d   = f_addr;
                  xfer_wdata_d  = '0;
                  xfer_wtag_d   = '0;
                  xfer_wforce_d = 1'b0;
                  xfer_opc_d    = OPC_FETCH;
                  f_gnt_d       = 1'b1;
                  run_cnt_d     = '0;
                  o_ad_d        = {44'b0, f_addr};
                  o_opc_d       = OPC_FETCH;
               end else begin
                  xfer_fetch_d  = 1'b0;
                  xfer_we_d     = d_we;
                  xfer_addr_d   = d_addr;
                  xfer_wdata_d  = d_wdata;
                  xfer_wtag_d   = d_wtag;
                  xfer_wforce_d = d_wforce;
                  xfer_opc_d    = d_opc;
                  d_gnt_d       = 1'b1;
                  if (f_req && (run_cnt_q != RUN_MAX)) begin
                     run_cnt_d = run_cnt_q + 1'b1;
                  end
                  o_ad_d        = {44'b0, d_addr};
                  o_opc_d       = d_opc;
               end
            end
         end

         ST_ADDR: begin
            state_d    = ST_DATA;
            wcnt_d     = '0;
            ws_ok_d    = (WAIT_STATES == 0);
            drive_data = 1'b1;
         end

         ST_DATA: begin
            if (ws_ok_q && i_rdy) begin
               state_d = ST_IDLE;
               if (xfer_fetch_q) f_done_d = 1'b1;
               else              d_done_d = 1'b1;
               if (!xfer_we_q) begin
                  rd_data_d = i_data;
                  rd_tag_d  = i_tag;
               end
            end else if (wcnt_q == TO_LAST) begin
               // Slave never answered: finish the transfer with an error.
               state_d   = ST_IDLE;
               if (xfer_fetch_q) f_done_d = 1'b1;
               else              d_done_d = 1'b1;
               d_err_d   = 1'b1;
               rd_data_d = '0;
               rd_tag_d  = '0;
            end else begin
               wcnt_d     = wcnt_q + 1'b1;
               if (wcnt_d == WS_LAST) ws_ok_d = 1'b1;
               drive_data = 1'b1;
            end
         end

         default: state_d = ST_IDLE;
      endcase

      // Data-phase pad values for the cycle after this edge
      if (drive_data) begin
         o_opc_d = xfer_opc_q;
         if (xfer_we_q) begin
            o_wr_d     = 1'b1;
            o_ad_d     = xfer_wdata_q;
            o_tag_d    = xfer_wtag_q;
            o_wforce_d = xfer_wforce_q;
         end else begin
            o_rd_d     = 1'b1;
         end
      end

      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= ST_IDLE;
         wcnt_q        <= '0;
         ws_ok_q       <= 1'b0;
         run_cnt_q     <= '0;
         xfer_fetch_q  <= 1'b0;
         xfer_we_q     <= 1'b0;
         xfer_addr_q   <= '0;
         xfer_wdata_q  <= '0;
         xfer_wtag_q   <= '0;
         xfer_wforce_q <= 1'b0;
         xfer_opc_q    <= '0;
         f_gnt_q       <= 1'b0;
         f_done_q      <= 1'b0;
         d_gnt_q       <= 1'b0;
         d_done_q      <= 1'b0;
         d_err_q       <= 1'b0;
         rd_data_q     <= '0;
         rd_tag_q      <= '0;
         o_ad_q        <= '0;
         o_tag_q       <= '0;
         o_astb_q      <= 1'b0;
         o_rd_q        <= 1'b0;
         o_wr_q        <= 1'b0;
         o_wforce_q    <= 1'b0;
         o_opc_q       <= '0;
         busy_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         wcnt_q        <= wcnt_d;
         ws_ok_q       <= ws_ok_d;
         run_cnt_q     <= run_cnt_d;
         xfer_fetch_q  <= xfer_fetch_d;
         xfer_we_q     <= xfer_we_d;
         xfer_addr_q   <= xfer_addr_d;
         xfer_wdata_q  <= xfer_wdata_d;
         xfer_wtag_q   <= xfer_wtag_d;
         xfer_wforce_q <= xfer_wforce_d;
         xfer_opc_q    <= xfer_opc_d;
         f_gnt_q       <= f_gnt_d;
         f_done_q      <= f_done_d;
         d_gnt_q       <= d_gnt_d;
         d_done_q      <= d_done_d;
         d_err_q       <= d_err_d;
         rd_data_q     <= rd_data_d;
         rd_tag_q      <= rd_tag_d;
         o_ad_q        <= o_ad_d;
         o_tag_q       <= o_tag_d;
         o_astb_q      <= o_astb_d;
         o_rd_q        <= o_rd_d;
         o_wr_q        <= o_wr_d;
         o_wforce_q    <= o_wforce_d;
         o_opc_q       <= o_opc_d;
         busy_q        <= busy_d;
      end
   end

   assign f_gnt    = f_gnt_q;
   assign f_done   = f_done_q;
   assign d_gnt    = d_gnt_q;
   assign d_done   = d_done_q;
   assign d_err    = d_err_q;
   assign rd_data  = rd_data_q;
   assign rd_tag   = rd_tag_q;
   assign o_ad     = o_ad_q;
   assign o_tag    = o_tag_q;
   assign o_astb   = o_astb_q;
   assign o_rd     = o_rd_q;
   assign o_wr     = o_wr_q;
   assign o_wforce = o_wforce_q;
   assign o_opc    = o_opc_q;
   assign busy     = busy_q;

endmodule

// File: tb/tb_membus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_membus_arbiter
//
// Directed bench for membus_arbiter. Instance "a" uses the default parameters
// (WAIT_STATES=0, MAX_DATA_RUN=2, TIMEOUT=64); instance "b" uses WAIT_STATES=3
// and is only checked in the wait-state scenario. Both share all inputs.
// Inputs change and outputs are sampled 1 time unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_membus_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        f_req;
   logic [19:0] f_addr;
   logic        d_req;
   logic [3:0]  d_opc;
   logic        d_we;
   logic [19:0] d_addr;
   logic [63:0] d_wdata;
   logic [7:0]  d_wtag;
   logic        d_wforce;
   logic [63:0] i_data;
   logic [7:0]  i_tag;
   logic        i_rdy;

   logic        a_f_gnt, a_f_done, a_d_gnt, a_d_done, a_d_err;
   logic [63:0] a_rd_data, a_o_ad;
   logic [7:0]  a_rd_tag, a_o_tag;
   logic        a_o_astb, a_o_rd, a_o_wr, a_o_wforce, a_busy;
   logic [3:0]  a_o_opc;

   logic        b_f_gnt, b_f_done, b_d_gnt, b_d_done, b_d_err;
   logic [63:0] b_rd_data, b_o_ad;
   logic [7:0]  b_rd_tag, b_o_tag;
   logic        b_o_astb, b_o_rd, b_o_wr, b_o_wforce, b_busy;
   logic [3:0]  b_o_opc;

   int tests_run = 0;
   int tests_failed = 0;

   always #5 clk = ~clk;

   membus_arbiter u_a (
      .clk(clk), .reset(reset),
      .f_req(f_req), .f_addr(f_addr), .f_gnt(a_f_gnt), .f_done(a_f_done),
      .d_req(d_req), .d_opc(d_opc), .d_we(d_we), .d_addr(d_addr),
      .d_wdata(d_wdata), .d_wtag(d_wtag), .d_wforce(d_wforce),
      .d_gnt(a_d_gnt), .d_done(a_d_done), .d_err(a_d_err),
      .rd_data(a_rd_data), .rd_tag(a_rd_tag),
      .o_ad(a_o_ad), .o_tag(a_o_tag), .o_astb(a_o_astb), .o_rd(a_o_rd),
      .o_wr(a_o_wr), .o_wforce(a_o_wforce), .o_opc(a_o_opc),
      .i_data(i_data), .i_tag(i_tag), .i_rdy(i_rdy), .busy(a_busy)
   );

   membus_arbiter #(.WAIT_STATES(3)) u_b (
      .clk(clk), .reset(reset),
      .f_req(f_req), .f_addr(f_addr), .f_gnt(b_f_gnt), .f_done(b_f_done),
      .d_req(d_req), .d_opc(d_opc), .d_we(d_we), .d_addr(d_addr),
      .d_wdata(d_wdata), .d_wtag(d_wtag), .d_wforce(d_wforce),
      .d_gnt(b_d_gnt), .d_done(b_d_done), .d_err(b_d_err),
      .rd_data(b_rd_data), .rd_tag(b_rd_tag),
      .o_ad(b_o_ad), .o_tag(b_o_tag), .o_astb(b_o_astb), .o_rd(b_o_rd),
      .o_wr(b_o_wr), .o_wforce(b_o_wforce), .o_opc(b_o_opc),
      .i_data(i_data), .i_tag(i_tag), .i_rdy(i_rdy), .busy(b_busy)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end else begin
         $display("ok   %s: %h", tag, got);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle_a(input string tag);
      int n;
      n = 0;
      while (a_busy && n < 100) begin
         tick();
         n++;
      end
      check(tag, a_busy, 1'b0);
   endtask

   initial begin
      int          n;
      int          gcount;
      int          rd_cycles;
      int          done_at;
      logic [5:0]  exp_order;

      reset = 1'b1; f_req = 1'b0; f_addr = '0; d_req = 1'b0; d_opc = '0;
      d_we = 1'b0; d_addr = '0; d_wdata = '0; d_wtag = '0; d_wforce = 1'b0;
      i_data = '0; i_tag = '0; i_rdy = 1'b0;

      // ---------------- reset state ----------------
      tick(); tick(); tick();
      reset = 1'b0;
      tick();
      check("rst_busy", a_busy, 1'b0);
      check("rst_astb", a_o_astb, 1'b0);
      check("rst_ad", a_o_ad, 64'h0);
      check("rst_done", {a_f_done, a_d_done, a_d_err}, 3'b000);
      check("rst_rd_data", a_rd_data, 64'h0);

      // ---------------- single fetch, 0 wait states ----------------
      f_req = 1'b1; f_addr = 20'h00123; i_rdy = 1'b1;
      i_data = 64'hDEAD; i_tag = 8'h5A;
      tick();                                         // T+1
      check("fetch_gnt", {a_f_gnt, a_d_gnt}, 2'b10);
      check("fetch_astb", a_o_astb, 1'b1);
      check("fetch_addr", a_o_ad, 64'h123);
      check("fetch_opc", a_o_opc, 4'd8);
      f_req = 1'b0;
      tick();                                         // T+2
      check("fetch_rd", {a_o_rd, a_o_wr, a_o_astb}, 3'b100);
      check("fetch_data_ad", a_o_ad, 64'h0);
      check("fetch_early_done", a_f_done, 1'b0);
      tick();                                         // T+3
      check("fetch_done", {a_f_done, a_d_done, a_d_err}, 3'b100);
      check("fetch_rd_data", a_rd_data, 64'hDEAD);
      check("fetch_rd_tag", a_rd_tag, 8'h5A);
      check("fetch_idle", {a_busy, a_o_rd}, 2'b00);
      tick();
      check("fetch_done_pulse", a_f_done, 1'b0);

      // ---------------- write with wforce ----------------
      d_req = 1'b1; d_opc = 4'h3; d_we = 1'b1; d_addr = 20'h3FF00;
      d_wdata = 64'h0123_4567_89AB_CDEF; d_wtag = 8'h35; d_wforce = 1'b1;
      i_data = 64'h1111;
      tick();
      check("wr_gnt", {a_f_gnt, a_d_gnt}, 2'b01);
      check("wr_addr", a_o_ad, 64'h3FF00);
      check("wr_opc", a_o_opc, 4'h3);
      d_req = 1'b0;
      tick();
      check("wr_strobes", {a_o_wr, a_o_rd, a_o_astb, a_o_wforce}, 4'b1001);
      check("wr_ad", a_o_ad, 64'h0123_4567_89AB_CDEF);
      check("wr_tag", a_o_tag, 8'h35);
      tick();
      check("wr_done", {a_d_done, a_d_err, a_f_done}, 3'b100);
      check("wr_keeps_rd_data", a_rd_data, 64'hDEAD);
      check("wr_strobe_off", {a_o_wr, a_o_wforce, a_o_tag}, 10'h0);
      tick();

      // ---------------- timeout on data read ----------------
      d_req = 1'b1; d_we = 1'b0; d_wforce = 1'b0; d_opc = 4'h1;
      d_addr = 20'h00400; i_rdy = 1'b0; i_data = 64'hFFFF;
      tick();                                         // T+1
      check("to_gnt", a_d_gnt, 1'b1);
      d_req = 1'b0;
      n = 1;
      while (!a_d_done && n < 200) begin
         tick();
         n++;
      end
      check("to_done_cycle", n, 66);
      check("to_err", {a_d_done, a_d_err, a_f_done}, 3'b110);
      check("to_rd_data", a_rd_data, 64'h0);
      check("to_busy", {a_busy, a_o_rd}, 2'b00);
      tick();
      check("to_err_pulse", a_d_err, 1'b0);

      // ---------------- priority: both requests held ----------------
      exp_order = 6'b100100;                         // D,D,F,D,D,F (bit0 first)
      i_rdy = 1'b1; i_data = 64'h2222;
      f_req = 1'b1; f_addr = 20'h00050; d_req = 1'b1; d_opc = 4'h2;
      gcount = 0;
      for (int c = 0; c < 60 && gcount < 6; c++) begin
         tick();
         check($sformatf("pri_not_both_c%0d", c), a_f_gnt & a_d_gnt, 1'b0);
         if (a_f_gnt || a_d_gnt) begin
            check($sformatf("pri_order_%0d", gcount), a_f_gnt, exp_order[gcount]);
            gcount++;
         end
      end
      check("pri_grant_count", gcount, 6);
      f_req = 1'b0; d_req = 1'b0;
      wait_idle_a("pri_idle");
      tick();

      // ---------------- reset during data phase ----------------
      d_req = 1'b1; d_opc = 4'h4; d_addr = 20'h00777; i_rdy = 1'b0;
      tick();
      d_req = 1'b0;
      tick();
      check("rmid_in_data", a_o_rd, 1'b1);
      reset = 1'b1;
      tick();
      check("rmid_strobes", {a_o_rd, a_o_wr, a_o_astb, a_busy}, 4'b0000);
      check("rmid_pulses", {a_d_done, a_d_err, a_d_gnt, a_f_done}, 4'b0000);
      check("rmid_ad_opc", {a_o_ad, a_o_opc}, 68'h0);
      reset = 1'b0; i_rdy = 1'b1;
      tick();
      check("rmid_no_done", {a_d_done, a_busy}, 2'b00);
      i_data = 64'hBEEF; i_tag = 8'h77;
      d_req = 1'b1;
      tick();
      check("rmid_fresh_gnt", a_d_gnt, 1'b1);
      d_req = 1'b0;
      tick();
      tick();
      check("rmid_fresh_done", {a_d_done, a_d_err}, 2'b10);
      check("rmid_fresh_data", a_rd_data, 64'hBEEF);
      tick();

      // ---------------- WAIT_STATES=3 (instance b) ----------------
      reset = 1'b1;
      tick();
      reset = 1'b0;
      tick();
      i_rdy = 1'b1; i_data = 64'hCAFE;
      d_req = 1'b1; d_opc = 4'h5; d_we = 1'b0;
      tick();                                         // T+1
      check("ws3_gnt", {b_d_gnt, b_o_astb}, 2'b11);
      d_req = 1'b0;
      rd_cycles = 0;
      done_at = 0;
      for (int k = 2; k <= 9; k++) begin
         tick();
         if (b_o_rd) rd_cycles++;
         if (b_d_done) done_at = k;
      end
      check("ws3_rd_cycles", rd_cycles, 4);
      check("ws3_done_at", done_at, 6);
      check("ws3_rd_data", b_rd_data, 64'hCAFE);
      check("ws3_idle", b_busy, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
